// File: rtl/pulse_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : pulse_pkg
//  Description : Shared definitions for the button/event path. Holds the FSM
//                state encoding and the default high/gap lengths used by both
//                the edge-to-pulse stage and the pulse stretcher.
//  Revision    : 1.0  initial release
// ============================================================================
package pulse_pkg;

  // FSM state encoding for the stretcher.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_HIGH = 2'b01;
  localparam logic [1:0] ST_GAP  = 2'b10;

  // Default phase lengths in clk cycles.
  localparam int DEFAULT_HIGH_CYCLES = 4;
  localparam int DEFAULT_GAP_CYCLES  = 2;

  // Larger of two integers; used to size shared down-counters.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : pulse_pkg
`default_nettype wire

// File: rtl/pulse_stretcher_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up/down counter that saturates at its maximum value and never
//                decrements below zero. An increment attempted at the maximum
//                (with no simultaneous decrement) is dropped and reported on
//                overflow for exactly one cycle.
//  Ports       : clk      - clock, posedge
//                rst      - asynchronous active-high reset
//                inc      - request to add one
//                dec      - request to subtract one (ignored at zero)
//                count    - current count, registered
//                overflow - high the cycle after an increment was dropped
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] C_MAX = '1;

  logic do_dec;
  logic at_max;

  assign do_dec = dec && (count != '0);
  assign at_max = (count == C_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      // Simultaneous inc and dec cancel out, even at the maximum.
      if (inc && !do_dec) begin
        if (at_max) begin
          overflow <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end else if (!inc && do_dec) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule : sat_counter
`default_nettype wire

// File: rtl/pulse_stretcher.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_stretcher
//  Description : Converts single-cycle request pulses into levels held high
//                for HIGH_CYCLES cycles, each followed by a GAP_CYCLES low gap.
//                Requests arriving while busy are queued in a saturating
//                counter; requests beyond its capacity are dropped and flagged.
//                HIGH_CYCLES and GAP_CYCLES must both be at least 1.
//  Ports       : clk       - clock, posedge
//                rst       - asynchronous active-high reset
//                pulse_in  - request, one per cycle sampled high
//                level_out - stretched output, registered
//                busy      - high while the FSM is not idle, registered
//                pending   - queued requests not yet started
//                overflow  - one-cycle flag after a request was dropped
//  Revision    : 1.0  initial release
// ============================================================================
module pulse_stretcher #(
  parameter int HIGH_CYCLES = pulse_pkg::DEFAULT_HIGH_CYCLES,
  parameter int GAP_CYCLES  = pulse_pkg::DEFAULT_GAP_CYCLES,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  import pulse_pkg::*;

  localparam int TIMER_W = $clog2(max_int(HIGH_CYCLES, GAP_CYCLES) + 1);

  localparam logic [TIMER_W-1:0] C_HIGH_LOAD = TIMER_W'(HIGH_CYCLES - 1);
  localparam logic [TIMER_W-1:0] C_GAP_LOAD  = TIMER_W'(GAP_CYCLES - 1);

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_nxt;
  logic               start_direct;
  logic               dequeue;
  logic               enqueue;
  logic               timer_done;
  logic               have_pending;

  assign timer_done   = (timer == '0);
  assign have_pending = (pending != '0);

  // A request is queued whenever it is not consumed by a direct start.
  assign enqueue = pulse_in && !start_direct;

  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    start_direct = 1'b0;
    dequeue      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pulse_in) begin
          start_direct = 1'b1;
          state_nxt    = ST_HIGH;
          timer_nxt    = C_HIGH_LOAD;
        end
      end
      ST_HIGH: begin
        if (timer_done) begin
          state_nxt = ST_GAP;
          timer_nxt = C_GAP_LOAD;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      ST_GAP: begin
        if (timer_done) begin
          // The queue has priority over a fresh pulse; that pulse is then
          // queued behind it instead.
          if (have_pending) begin
            dequeue   = 1'b1;
            state_nxt = ST_HIGH;
            timer_nxt = C_HIGH_LOAD;
          end else if (pulse_in) begin
            start_direct = 1'b1;
            state_nxt    = ST_HIGH;
            timer_nxt    = C_HIGH_LOAD;
          end else begin
            state_nxt = ST_IDLE;
            timer_nxt = '0;
          end
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      timer     <= '0;
      level_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      // Outputs follow the state one cycle later, so level_out and busy
      // rise together on the cycle after a start.
      level_out <= (state == ST_HIGH);
      busy      <= (state != ST_IDLE);
    end
  end

  sat_counter #(
    .WIDTH (PEND_W)
  ) u_pending (
    .clk      (clk),
    .rst      (rst),
    .inc      (enqueue),
    .dec      (dequeue),
    .count    (pending),
    .overflow (overflow)
  );

endmodule : pulse_stretcher
`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_stretcher
//  Description : Self-checking bench for pulse_stretcher at default settings
//                (HIGH=4, GAP=2, capacity 7).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pulse_stretcher;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pulse_in = 1'b0;
  logic       level_out;
  logic       busy;
  logic [2:0] pending;
  logic       overflow;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pulse_stretcher #(
    .HIGH_CYCLES (4),
    .GAP_CYCLES  (2),
    .PEND_W      (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pulse_in  (pulse_in),
    .level_out (level_out),
    .busy      (busy),
    .pending   (pending),
    .overflow  (overflow)
  );

  typedef struct {
    logic       pulse;
    logic       lvl;
    logic       bsy;
    logic [2:0] pend;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  // Append n identical rows: input pulse, then outputs expected after the edge.
  task automatic add_vec(input int n, input logic p, input logic l, input logic b,
                         input logic [2:0] pe, input logic o);
    vec_t v;
    v.pulse = p; v.lvl = l; v.bsy = b; v.pend = pe; v.ovf = o;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic cycle(input logic p);
    pulse_in = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- vector table ----------------
    // Single pulse at edge 0
    add_vec(1, 1, 0, 0, 0, 0);
    add_vec(4, 0, 1, 1, 0, 0);
    add_vec(2, 0, 0, 1, 0, 0);
    add_vec(1, 0, 0, 0, 0, 0);
    // Pulses at edges 0, 1, 2
    add_vec(1, 1, 0, 0, 0, 0);
    add_vec(1, 1, 1, 1, 1, 0);
    add_vec(1, 1, 1, 1, 2, 0);
    add_vec(2, 0, 1, 1, 2, 0);
    add_vec(1, 0, 0, 1, 2, 0);
    add_vec(1, 0, 0, 1, 1, 0);
    add_vec(4, 0, 1, 1, 1, 0);
    add_vec(1, 0, 0, 1, 1, 0);
    add_vec(1, 0, 0, 1, 0, 0);
    add_vec(4, 0, 1, 1, 0, 0);
    add_vec(2, 0, 0, 1, 0, 0);
    add_vec(1, 0, 0, 0, 0, 0);
    // Pulse on the last gap cycle with nothing pending: immediate restart
    add_vec(1, 1, 0, 0, 0, 0);
    add_vec(4, 0, 1, 1, 0, 0);
    add_vec(1, 0, 0, 1, 0, 0);
    add_vec(1, 1, 0, 1, 0, 0);
    add_vec(4, 0, 1, 1, 0, 0);
    add_vec(2, 0, 0, 1, 0, 0);
    add_vec(1, 0, 0, 0, 0, 0);

    // ---------------- reset state ----------------
    rst = 1'b1;
    pulse_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.level", level_out, 0);
    chk("reset.busy", busy, 0);
    chk("reset.pending", pending, 0);
    chk("reset.overflow", overflow, 0);
    rst = 1'b0;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].pulse);
      chk($sformatf("vec%0d.level", i), level_out, vecs[i].lvl);
      chk($sformatf("vec%0d.busy", i), busy, vecs[i].bsy);
      chk($sformatf("vec%0d.pending", i), pending, vecs[i].pend);
      chk($sformatf("vec%0d.overflow", i), overflow, vecs[i].ovf);
    end

    // ---------------- held pulse: saturation and overflow ----------------
    begin
      int   highs = 0;
      int   ovf_cnt = 0;
      int   pmax = 0;
      logic prev_l = 1'b0;
      for (int k = 0; k < 120; k++) begin
        cycle(k < 10);
        if (level_out && !prev_l) highs++;
        prev_l = level_out;
        if (overflow) ovf_cnt++;
        if (int'(pending) > pmax) pmax = int'(pending);
        if (k == 8) begin
          chk("hold.pending_e8", pending, 7);
          chk("hold.overflow_e8", overflow, 0);
        end
        if (k == 9) begin
          chk("hold.pending_e9", pending, 7);
          chk("hold.overflow_e9", overflow, 1);
        end
        if (k == 10) chk("hold.overflow_e10", overflow, 0);
        if (k > 10 && !busy) break;
      end
      chk("hold.drained", busy, 0);
      chk("hold.high_phases", highs, 9);
      chk("hold.overflow_cycles", ovf_cnt, 1);
      chk("hold.pending_peak", pmax, 7);
      chk("hold.pending_end", pending, 0);
    end

    // ---------------- asynchronous reset mid-operation ----------------
    cycle(1'b0);
    cycle(1'b1);
    cycle(1'b1);
    cycle(1'b1);
    cycle(1'b1);
    chk("arst.pre_level", level_out, 1);
    chk("arst.pre_pending", pending, 3);
    pulse_in = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst.level", level_out, 0);
    chk("arst.busy", busy, 0);
    chk("arst.pending", pending, 0);
    chk("arst.overflow", overflow, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    begin
      int replay = 0;
      for (int k = 0; k < 10; k++) begin
        cycle(1'b0);
        if (level_out || busy || pending != 3'd0) replay++;
      end
      chk("arst.no_replay", replay, 0);
    end
    cycle(1'b1);
    chk("arst.fresh_e0_level", level_out, 0);
    cycle(1'b0);
    chk("arst.fresh_e1_level", level_out, 1);
    chk("arst.fresh_e1_busy", busy, 1);
    chk("arst.fresh_pending", pending, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_pulse_stretcher
`default_nettype wire

// File: doc/pulse_stretcher.md
# pulse_stretcher

Pulse-to-level converter for the button/event path. Consumes the single-cycle pulses produced by the edge-to-pulse stage and replays each one as a level held high for a fixed number of cycles. Each level is followed by a mandatory low gap, so every pulse stays visible on slow consumers such as LEDs, status pins or a UART strobe. Pulses that arrive while a level is being driven are queued in a saturating counter; pulses beyond its capacity are dropped and flagged.

## Interface
- HIGH_CYCLES, 4, length of each high phase in clk cycles; must be ≥1
- GAP_CYCLES, 2, length of the low gap after each high phase; must be ≥1
- PEND_W, 3, width of the pending counter; capacity is 2^PEND_W−1 (7 at default)

Ports:
- clk  in  1  system clock; everything is on posedge
- rst  in  1  asynchronous, active-high reset
- pulse_in  in  1  request; every cycle sampled high counts as one request
- level_out  out  1  stretched output, registered
- busy  out  1  high whenever state ≠ IDLE
- pending  out  PEND_W  number of queued, not-yet-started requests
- overflow  out  1  one-cycle flag, high for the cycle after a request was dropped

## Operation
- FSM states: IDLE, HIGH, GAP. Down-counter `timer` is sized $clog2(max(HIGH_CYCLES, GAP_CYCLES)+1).
- Start event: a transition into HIGH. It loads timer with HIGH_CYCLES−1, and level_out goes to 1 from the next cycle.
- IDLE:
  - pulse_in=1 → start. The request is consumed directly and pending is unchanged.
- HIGH:
  - timer decrements each cycle.
  - At timer=0 → GAP, with timer loaded to GAP_CYCLES−1.
- GAP:
  - timer decrements each cycle.
  - At timer=0, if pending>0 → start from queue (pending −1). The pulse_in of that same cycle, if high, is enqueued.
  - At timer=0, else if pulse_in=1 → start directly.
  - At timer=0, else → IDLE.
- Enqueue: pulse_in=1 in any cycle where it is not consumed by a direct start.
- Pending update: next = pending + enqueue − dequeue.
  - Simultaneous enqueue and dequeue leaves pending unchanged.
  - Enqueue with pending at max and no dequeue: the request is dropped and overflow is 1 for the next cycle.
- pending never wraps. Decrement occurs only when pending>0.
- Reset asserted mid-operation: queued requests are discarded. There is no resume.

## Timing
- Reset values: level_out=0, busy=0, pending=0, overflow=0, state=IDLE, timer=0. Outputs clear asynchronously on rst rising.
- First rising edge after rst deasserts is the first sampling edge.
- Latency: pulse_in sampled at edge N in IDLE → level_out=1 after edge N+1 through edge N+HIGH_CYCLES, low for the following GAP_CYCLES cycles.
- Back-to-back service: period HIGH_CYCLES+GAP_CYCLES per request. A queued start occurs at the edge that ends the gap, with no extra idle cycle.
- busy rises with the level_out rise. It falls one cycle after the gap ends with nothing pending.
- All outputs are registered. There is no combinational path from pulse_in to any output.

## Structure
- Shared package `pulse_pkg`: state encoding (IDLE=2'b00, HIGH=2'b01, GAP=2'b10) and the default HIGH/GAP cycle constants, also used by the edge-to-pulse stage.
- Optional sub-module `sat_counter`: up/down counter with saturate-at-max, no-decrement-below-zero and an overflow output. The FSM and timer stay in the top module.

## Test plan
All scenarios use defaults (HIGH=4, GAP=2, capacity 7).

- Single pulse at edge 0 → level_out high for exactly 4 cycles from edge 1, then low. busy high for 6 cycles. pending stays 0.
- Pulses at edges 0, 1, 2 → three 4-cycle highs separated by 2-cycle lows. pending goes 1, 2, then decrements to 0 at each gap end. No overflow.
- pulse_in held high for edges 0–9 → exactly 9 high phases, overflow high for exactly one cycle (after edge 9), pending peaks at 7 and never wraps.
- Pending=0 and a pulse on the last GAP cycle → next high starts immediately with no IDLE cycle and no gap extension. pending stays 0.
- rst asserted during the 3rd HIGH cycle with pending=3 → level_out, busy and pending go to 0 without waiting for a clock edge. After release, no queued pulses replay, and a fresh pulse gives the normal 1-cycle latency.
